// File: rtl/multibyte_add_pkg.sv
// Shared types and constants for the byte-serial multi-byte adder.
// Holds the FSM state encoding and the byte slice width.
package multibyte_add_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multibyte_add_seq_if.sv
// Operand/result handshake bundle for multibyte_add_seq.
// The master drives operands and out_ready; the slave (the adder) drives the result side.
interface multibyte_add_seq_if
   import multibyte_add_pkg::*;
#(
   parameter int NBYTES = 4
) ();

   logic                     in_valid;
   logic                     in_ready;
   logic [BYTE_W*NBYTES-1:0] op_a;
   logic [BYTE_W*NBYTES-1:0] op_b;
   logic                     cin;
   logic                     out_valid;
   logic                     out_ready;
   logic [BYTE_W*NBYTES-1:0] result;
   logic                     cout;

   modport master (
      output in_valid, op_a, op_b, cin, out_ready,
      input  in_ready, out_valid, result, cout
   );

   modport slave (
      input  in_valid, op_a, op_b, cin, out_ready,
      output in_ready, out_valid, result, cout
   );

endinterface

// File: rtl/carry_bypass_adder8.sv
// 8-bit adder built from two 4-bit ripple blocks, each with a propagate bypass on its carry.
// Purely combinational; no handshake.
module carry_bypass_adder8
   import multibyte_add_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   always_comb begin : chain
      logic c;
      logic blk_cin;
      logic blk_p;
      sum     = '0;
      c       = cin;
      blk_cin = 1'b0;
      blk_p   = 1'b0;
      for (int blk = 0; blk < 2; blk++) begin
         blk_cin = c;
         blk_p   = 1'b1;
         for (int i = 0; i < 4; i++) begin
            sum[blk*4+i] = a[blk*4+i] ^ b[blk*4+i] ^ c;
            c            = (a[blk*4+i] & b[blk*4+i]) | (c & (a[blk*4+i] ^ b[blk*4+i]));
            blk_p        = blk_p & (a[blk*4+i] ^ b[blk*4+i]);
         end
         // When every bit of the block propagates, the block's carry-in skips straight through.
         c = blk_p ? blk_cin : c;
      end
      cout = c;
   end

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial adder: result = op_a + op_b + cin, one byte per cycle, LSB first; out_valid NBYTES cycles after accept.
// Accepts only in IDLE; result/cout hold in DONE until out_ready, and no new accept on the handshake cycle.
module multibyte_add_seq
   import multibyte_add_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   multibyte_add_seq_if.slave bus
);

   localparam int IDX_W = $clog2(NBYTES);

   state_t                         state;
   state_t                         state_nxt;
   logic [IDX_W-1:0]               idx;
   logic [NBYTES-1:0][BYTE_W-1:0]  opa_q;
   logic [NBYTES-1:0][BYTE_W-1:0]  opb_q;
   logic [NBYTES-1:0][BYTE_W-1:0]  res_q;
   logic                           carry_q;
   logic                           cout_q;
   logic                           accept;
   logic                           last_byte;
   logic [BYTE_W-1:0]              slice_sum;
   logic                           slice_cout;

   assign last_byte = (idx == IDX_W'(NBYTES - 1));

   carry_bypass_adder8 u_slice (
      .a    (opa_q[idx]),
      .b    (opb_q[idx]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_byte) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         opa_q   <= bus.op_a;
         opb_q   <= bus.op_b;
         carry_q <= bus.cin;
         idx     <= '0;
      end else if (state == ST_RUN) begin
         res_q[idx] <= slice_sum;
         carry_q    <= slice_cout;
         if (last_byte) begin
            cout_q <= slice_cout;
            idx    <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign bus.result = res_q;
   assign bus.cout   = cout_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed and randomised checks of multibyte_add_seq with NBYTES=4.
module tb_multibyte_add_seq;

   localparam int NB = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_run  = 0;
   int   n_fail = 0;

   multibyte_add_seq_if #(.NBYTES(NB)) bus ();

   multibyte_add_seq #(.NBYTES(NB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation: accept, latency, result, optional hold with out_ready low, handshake.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic [31:0] er, input logic ec, input int hold,
                         input bit poke, input bit early);
      int cyc;
      cyc = 0;
      while (!bus.in_ready && cyc < 50) begin
         tick();
         cyc++;
      end
      if (cyc >= 50) chk("ready_timeout", 64'(cyc), 64'd0);
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.cin      = ci;
      tick();
      // Scramble inputs after acceptance; the running op must not see them.
      bus.in_valid = 1'b0;
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
      bus.cin      = 1'($urandom);
      cyc = 0;
      while (!bus.out_valid && cyc < 50) begin
         chk("run_in_ready", 64'(bus.in_ready), 64'd0);
         if (poke && cyc == 1) begin
            bus.in_valid = 1'b1;
            bus.op_a     = 32'hFFFF_FFFF;
            bus.op_b     = 32'hFFFF_FFFF;
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
         cyc++;
      end
      bus.in_valid = 1'b0;
      chk("latency", 64'(cyc), 64'(NB));
      chk("result", 64'(bus.result), 64'(er));
      chk("cout", 64'(bus.cout), 64'(ec));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_sum", 64'({bus.cout, bus.result}), 64'({ec, er}));
         chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
         chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      if (early) begin
         bus.in_valid = 1'b1;
         bus.op_a     = 32'h0000_0005;
         bus.op_b     = 32'h0000_0007;
         bus.cin      = 1'b1;
      end
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("hs_out_valid", 64'(bus.out_valid), 64'd0);
      chk("hs_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic [32:0] model;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      rst = 1'b0;
      tick();

      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 0, 1'b0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b0);
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 5, 1'b0, 1'b1);
      run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1, 1'b1, 1'b0);

      // Abort mid-run: reset while idx=2.
      bus.in_valid = 1'b1;
      bus.op_a     = 32'h1111_1111;
      bus.op_b     = 32'h2222_2222;
      bus.cin      = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_result", 64'(bus.result), 64'd0);
      chk("abort_cout", 64'(bus.cout), 64'd0);
      chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("abort_no_out_valid", 64'(bus.out_valid), 64'd0);
      end
      run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_000D, 1'b0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         ra    = $urandom;
         rb    = $urandom;
         rc    = 1'($urandom);
         model = {1'b0, ra} + {1'b0, rb} + 33'(rc);
         run_op(ra, rb, rc, model[31:0], model[32], int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 Parameter NBYTES: default 4; number of byte slices per operation; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand set present on op_a/op_b/cin.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 op_a  input  8*NBYTES  addend A, unsigned.
REQ-007 op_b  input  8*NBYTES  addend B, unsigned.
REQ-008 cin  input  1  carry into byte 0.
REQ-009 out_valid  output  1  result/cout valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  8*NBYTES  sum bits, modulo 2^(8*NBYTES).
REQ-012 cout  output  1  carry out of the most significant byte.

Function
REQ-013 The block SHALL compute op_a + op_b + cin one byte per cycle, least significant byte first, through a single 8-bit adder slice.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1, latch op_a, op_b and cin into operand registers, clear the byte index to 0, go to RUN.
REQ-016 RUN: each cycle, add byte[idx] of A and B with the carry register, write the 8-bit sum into result byte[idx], update the carry register with the slice carry-out, and increment idx.
REQ-017 RUN: when idx=NBYTES-1 completes, go to DONE and set cout to the final carry.
REQ-018 Latency SHALL be exactly NBYTES cycles from the accepting edge to the first edge where out_valid=1.
REQ-019 DONE: out_valid=1; result and cout SHALL hold stable until out_ready=1; on out_ready=1, go to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and the operands left unlatched.
REQ-021 A new operand set SHALL NOT be accepted in the same cycle as the output handshake; it is accepted no earlier than the following cycle, in IDLE.
REQ-022 Changes on op_a/op_b/cin after acceptance SHALL NOT affect the running operation.
REQ-023 out_valid SHALL be 0 in IDLE and RUN; result/cout keep their last values in IDLE.
REQ-024 Carry wrap-around: all-ones + 0 + cin=1 SHALL yield result=0, cout=1.

Reset
REQ-025 rst=1 SHALL asynchronously force state to IDLE, with idx=0, carry register=0, operand registers=0, result=0, cout=0, out_valid=0 and in_ready=1 after release.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation without emitting out_valid; the first accept after release SHALL start a clean operation.

Structure
REQ-027 FSM state enum and the BYTE_W=8 constant SHALL live in a shared package, multibyte_add_pkg.
REQ-028 The byte slice SHALL be a single instance of the existing 8-bit carry-bypass adder, carry_bypass_adder8 (a, b, cin -> sum, cout); no other sub-module.
REQ-029 The adder slice SHALL be the only arithmetic path; idx select and carry register are local logic.

Verification
REQ-030 NBYTES=4, A=0x000000FF, B=0x00000001, cin=0 -> result=0x00000100, cout=0, out_valid exactly 4 cycles after accept.
REQ-031 A=0xFFFFFFFF, B=0x00000000, cin=1 -> result=0x00000000, cout=1.
REQ-032 A=0x12345678, B=0x9ABCDEF0, cin=0, out_ready=0 for 5 cycles after done -> result=0xACF13568, cout=0 held stable, in_ready=0 throughout, accept only after handshake+1 cycle.
REQ-033 in_valid pulsed with A=B=0xFFFFFFFF during RUN of op A=1,B=2 -> result=0x00000003; second set not accepted.
REQ-034 rst pulsed at RUN idx=2 -> out_valid never asserted, all outputs 0, next op 5+7 cin=1 -> result=0x0000000D.
REQ-035 Random back-to-back ops (>=1000) with random out_ready -> every result/cout matches a reference model {cout,result}=A+B+cin.
